// File: rtl/phase_add_seq.sv
// Phase sequencer for the bit-serial four-phase NOR-latch adder cell.
// Strobes t0..t3 per bit position, LSB first, and collects the returned sum/carry.
module phase_add_seq #(
    parameter int WIDTH     = 8,
    parameter int PHASE_LEN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH-1:0]         op_a,
    input  logic [WIDTH-1:0]         op_b,
    input  logic                     cin,
    input  logic                     sum_bit,
    input  logic                     cout_bit,
    output logic                     t0,
    output logic                     t1,
    output logic                     t2,
    output logic                     t3,
    output logic                     a_bit,
    output logic                     b_bit,
    output logic                     c_bit,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     cout
);

    localparam int IDXW = $clog2(WIDTH);
    localparam int PCW  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH0  = 3'd1,
        PH1  = 3'd2,
        PH2  = 3'd3,
        PH3  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state;
    logic [PCW-1:0]   phase_cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             phase_end;
    logic             last_bit;

    assign phase_end = (phase_cnt == PCW'(PHASE_LEN - 1));
    assign last_bit  = (bit_idx == IDXW'(WIDTH - 1));

    // Operand shifters keep the next bit at index 1 so a_bit/b_bit are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            t0        <= 1'b0;
            t1        <= 1'b0;
            t2        <= 1'b0;
            t3        <= 1'b0;
            a_bit     <= 1'b0;
            b_bit     <= 1'b0;
            c_bit     <= 1'b0;
            bit_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= op_a;
                        b_sh      <= op_b;
                        carry     <= cin;
                        a_bit     <= op_a[0];
                        b_bit     <= op_b[0];
                        c_bit     <= cin;
                        bit_idx   <= '0;
                        result    <= '0;
                        cout      <= 1'b0;
                        phase_cnt <= '0;
                        busy      <= 1'b1;
                        t0        <= 1'b1;
                        state     <= PH0;
                    end else begin
                        state <= IDLE;
                    end
                end
                PH0: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        t0        <= 1'b0;
                        t1        <= 1'b1;
                        state     <= PH1;
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                    end
                end
                PH1: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        t1        <= 1'b0;
                        t2        <= 1'b1;
                        state     <= PH2;
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                    end
                end
                PH2: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        t2        <= 1'b0;
                        t3        <= 1'b1;
                        state     <= PH3;
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                    end
                end
                PH3: begin
                    if (phase_end) begin
                        phase_cnt       <= '0;
                        t3              <= 1'b0;
                        result[bit_idx] <= sum_bit;
                        carry           <= cout_bit;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + IDXW'(1);
                            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                            a_bit   <= a_sh[1];
                            b_bit   <= b_sh[1];
                            c_bit   <= cout_bit;
                            t0      <= 1'b1;
                            state   <= PH0;
                        end else begin
                            cout  <= cout_bit;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PCW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    t0    <= 1'b0;
                    t1    <= 1'b0;
                    t2    <= 1'b0;
                    t3    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_add_seq.sv
// Directed bench for phase_add_seq: PHASE_LEN=1 and PHASE_LEN=2 instances,
// each closed through a behavioural full adder.
module tb_phase_add_seq;

    typedef struct packed {
        logic [3:0] t;
        logic       busy;
        logic       done;
        logic       a;
        logic       b;
        logic       c;
        logic [2:0] idx;
        logic       cout;
        logic [7:0] res;
    } obs_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        int         extra;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start0 = 1'b0, cin0 = 1'b0, start1 = 1'b0, cin1 = 1'b0;
    logic [7:0] opa0 = 8'h00, opb0 = 8'h00, opa1 = 8'h00, opb1 = 8'h00;
    logic       s0, co0, s1, co1;
    logic       t00, t10, t20, t30, ab0, bb0, cb0, busy0, done0, cout0;
    logic       t01, t11, t21, t31, ab1, bb1, cb1, busy1, done1, cout1;
    logic [2:0] idx0, idx1;
    logic [7:0] res0, res1;
    obs_t       o0, o1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int strobe_err = 0;

    always #5 clk = ~clk;

    phase_add_seq #(.WIDTH(8), .PHASE_LEN(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(opa0), .op_b(opb0), .cin(cin0),
        .sum_bit(s0), .cout_bit(co0), .t0(t00), .t1(t10), .t2(t20), .t3(t30),
        .a_bit(ab0), .b_bit(bb0), .c_bit(cb0), .bit_idx(idx0), .busy(busy0),
        .done(done0), .result(res0), .cout(cout0)
    );

    phase_add_seq #(.WIDTH(8), .PHASE_LEN(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(opa1), .op_b(opb1), .cin(cin1),
        .sum_bit(s1), .cout_bit(co1), .t0(t01), .t1(t11), .t2(t21), .t3(t31),
        .a_bit(ab1), .b_bit(bb1), .c_bit(cb1), .bit_idx(idx1), .busy(busy1),
        .done(done1), .result(res1), .cout(cout1)
    );

    assign s0  = ab0 ^ bb0 ^ cb0;
    assign co0 = (ab0 & bb0) | (ab0 & cb0) | (bb0 & cb0);
    assign s1  = ab1 ^ bb1 ^ cb1;
    assign co1 = (ab1 & bb1) | (ab1 & cb1) | (bb1 & cb1);

    assign o0 = {t00, t10, t20, t30, busy0, done0, ab0, bb0, cb0, idx0, cout0, res0};
    assign o1 = {t01, t11, t21, t31, busy1, done1, ab1, bb1, cb1, idx1, cout1, res1};

    function automatic obs_t get_obs(input int sel);
        return (sel == 0) ? o0 : o1;
    endfunction

    // Strobe exclusivity and idle-quiet strobes, watched over the whole run.
    always @(negedge clk) begin
        if ($countones(o0.t) > 1 || (!o0.busy && o0.t != 4'b0000)) strobe_err++;
        if ($countones(o1.t) > 1 || (!o1.busy && o1.t != 4'b0000)) strobe_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // One complete operation with fixed latency; extra>0 pulses a second start at that cycle.
    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] er, input logic ec,
                          input int pl, input int extra);
        int   n;
        int   errs;
        int   k;
        int   pos;
        logic mc;
        obs_t o;
        n    = 4 * pl * 8;
        errs = 0;
        mc   = c;
        @(negedge clk);
        if (sel == 0) begin
            opa0 = a; opb0 = b; cin0 = c; start0 = 1'b1;
        end else begin
            opa1 = a; opb1 = b; cin1 = c; start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            @(negedge clk);
            o   = get_obs(sel);
            k   = (cyc - 1) / (4 * pl);
            pos = (cyc - 1) % (4 * pl);
            if (o.t !== (4'b1000 >> (pos / pl))) errs++;
            if (o.busy !== 1'b1 || o.done !== 1'b0) errs++;
            if (o.idx !== 3'(k)) errs++;
            if (o.a !== a[k] || o.b !== b[k] || o.c !== mc) errs++;
            if (pos == 4 * pl - 1) mc = (a[k] & b[k]) | (a[k] & mc) | (b[k] & mc);
            if (sel == 0 && cyc == extra) begin
                opa0 = 8'hAA; opb0 = 8'h55; start0 = 1'b1;
            end else if (cyc == extra + 1) begin
                start0 = 1'b0;
            end else begin
                start0 = start0;
            end
        end
        check("phase_sequence", 32'(errs), 32'd0);
        @(negedge clk);
        o = get_obs(sel);
        check("done_cycle", {30'd0, o.done, o.busy}, {30'd0, 1'b1, 1'b0});
        check("result", {24'd0, o.res}, {24'd0, er});
        check("cout", {31'd0, o.cout}, {31'd0, ec});
        @(negedge clk);
        o = get_obs(sel);
        check("after_done_idle", {28'd0, o.t, o.done, o.busy}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 8'h3C, b: 8'h05, cin: 1'b0, res: 8'h41, cout: 1'b0, extra: -5};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, res: 8'h00, cout: 1'b1, extra: -5};
        vecs[2] = '{a: 8'h10, b: 8'h20, cin: 1'b0, res: 8'h30, cout: 1'b0, extra: 10};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, res: 8'hFF, cout: 1'b1, extra: -5};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, res: 8'h00, cout: 1'b0, extra: -5};
        vecs[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, res: 8'h00, cout: 1'b1, extra: -5};

        #12;
        check("reset_state0", 32'(o0), 32'd0);
        check("reset_state1", 32'(o1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cout, 1, vecs[i].extra);

        run_op(1, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 2, -5);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        opa0 = 8'h3C; opb0 = 8'h05; cin0 = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        check("busy_before_reset", {31'd0, o0.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_clears", 32'(o0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_after_abort", 32'(o0), 32'd0);
        run_op(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1, -5);

        check("strobe_exclusive", 32'(strobe_err), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
